// File: rtl/seqsec_pkg.sv
// seqsec_pkg: shared FSM/size types and sequential-section row math for the TCDM remap stage
//   seq_lg(k, rw)            log2 of the per-bank sequential row count (valid when k != 0)
//   seq_rows(k, bank_rows)   R = 0 for k = 0, else min(2^(k-1), bank_rows)
package seqsec_pkg;
  typedef enum logic {RUN, DRAIN} state_e;
  typedef logic [3:0] size_t;
  function automatic int unsigned seq_lg(size_t k, int unsigned rw);
    return (k == 4'd0) ? 0 : ((32'(k) - 1 > rw) ? rw : 32'(k) - 1);
  endfunction
  function automatic int unsigned seq_rows(size_t k, int unsigned bank_rows);
    return (k == 4'd0) ? 0 : 32'd1 << seq_lg(k, $clog2(bank_rows));
  endfunction
endpackage

// File: rtl/seqsec_tcdm_remap_if.sv
// seqsec_tcdm_remap_if: core-side TCDM port (req/gnt, address, write data, read response)
//   master: core driving requests; slave: remap stage accepting them
interface seqsec_tcdm_remap_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);
  logic                  req, gnt, wen, r_valid;
  logic [ADDR_WIDTH-1:0] add;
  logic [DATA_WIDTH-1:0] wdata, r_rdata;
  logic [BE_WIDTH-1:0]   be;
  modport master (output req, add, wen, wdata, be, input gnt, r_valid, r_rdata);
  modport slave (input req, add, wen, wdata, be, output gnt, r_valid, r_rdata);
endinterface

// File: rtl/seqsec_addr_xlate.sv
// seqsec_addr_xlate: combinational word address -> {bank, row} with a sequential section below interleaving
//   w_i     word address        size_i  sequential-section size code
//   bank_o  target bank         row_o   row within bank
module seqsec_addr_xlate
  import seqsec_pkg::*;
#(
  parameter int N_BANKS   = 16,
  parameter int BANK_ROWS = 1024,
  localparam int BW = $clog2(N_BANKS),
  localparam int RW = $clog2(BANK_ROWS),
  localparam int WW = BW + RW
) (
  input  logic [WW-1:0] w_i,
  input  size_t         size_i,
  output logic [BW-1:0] bank_o,
  output logic [RW-1:0] row_o
);
  localparam logic [WW:0] ONE = (WW + 1)'(1);
  logic [WW:0] we, rr, base, off;
  int unsigned lg;
  logic in_seq;
  // base = N_BANKS*R is the first interleaved word; R = 0 makes everything interleaved
  always_comb begin
    lg = seq_lg(size_i, RW);
    rr = (WW + 1)'(seq_rows(size_i, BANK_ROWS));
    we = {1'b0, w_i};
    base = rr << BW;
    off = we - base;
    in_seq = we < base;
    bank_o = in_seq ? BW'(we >> lg) : off[BW-1:0];
    row_o = in_seq ? RW'(we & (rr - ONE)) : RW'(rr + (off >> BW));
  end
endmodule

// File: rtl/seqsec_tcdm_remap.sv
// seqsec_tcdm_remap: registered TCDM request stage with seqsec address remap and drain-on-resize
//   clk_i/rst_ni    clock, async active-low reset
//   seqsec_size_i   sequential-section size from the MMU config bus
//   core            core-side TCDM port (slave)
//   bank_*          bank-side request, grant and one-cycle-later response
module seqsec_tcdm_remap
  import seqsec_pkg::*;
#(
  parameter int N_BANKS    = 16,
  parameter int BANK_ROWS  = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 32,
  localparam int BW = $clog2(N_BANKS),
  localparam int RW = $clog2(BANK_ROWS),
  localparam int WW = BW + RW
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  size_t                 seqsec_size_i,
  seqsec_tcdm_remap_if.slave    core,
  output logic                  bank_req_o,
  input  logic                  bank_gnt_i,
  output logic [BW-1:0]         bank_sel_o,
  output logic [RW-1:0]         bank_row_o,
  output logic                  bank_wen_o,
  output logic [DATA_WIDTH-1:0] bank_wdata_o,
  output logic [BE_WIDTH-1:0]   bank_be_o,
  input  logic                  bank_r_valid_i,
  input  logic [DATA_WIDTH-1:0] bank_r_rdata_i
);
  state_e        state_q;
  size_t         cfg_q;
  logic          valid_q, accept, issue, unused_add;
  logic [1:0]    out_q, out_d;
  logic [BW-1:0] bank_d;
  logic [RW-1:0] row_d;
  seqsec_addr_xlate #(.N_BANKS(N_BANKS), .BANK_ROWS(BANK_ROWS)) u_xlate (
    .w_i   (core.add[2 +: WW]),
    .size_i(cfg_q),
    .bank_o(bank_d),
    .row_o (row_d)
  );
  assign unused_add = ^{core.add[ADDR_WIDTH-1:2+WW], core.add[1:0]};
  assign core.gnt = (state_q == RUN) && (!valid_q || bank_gnt_i);
  assign core.r_valid = bank_r_valid_i;
  assign core.r_rdata = bank_r_rdata_i;
  assign bank_req_o = valid_q;
  assign accept = core.req && core.gnt;
  assign issue = valid_q && bank_gnt_i;
  assign out_d = (issue && !bank_r_valid_i) ? out_q + 2'd1 : (!issue && bank_r_valid_i) ? out_q - 2'd1 : out_q;
  // a resize seen in RUN still lets that cycle's request through under the old cfg_q
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cfg_q <= '0;
      valid_q <= 1'b0;
      out_q <= '0;
      bank_sel_o <= '0;
      bank_row_o <= '0;
      bank_wen_o <= 1'b0;
      bank_wdata_o <= '0;
      bank_be_o <= '0;
    end else begin
      out_q <= out_d;
      if (accept) begin
        valid_q <= 1'b1;
        bank_sel_o <= bank_d;
        bank_row_o <= row_d;
        bank_wen_o <= core.wen;
        bank_wdata_o <= core.wdata;
        bank_be_o <= core.be;
      end else if (bank_gnt_i) begin
        valid_q <= 1'b0;
      end
      if (state_q == RUN) begin
        state_q <= (seqsec_size_i != cfg_q) ? DRAIN : RUN;
      end else if (!valid_q && out_q == 2'd0) begin
        cfg_q <= seqsec_size_i;
        state_q <= RUN;
      end
    end
  end
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(bank_r_valid_i && out_q == 2'd0));
endmodule

// File: tb/tb_seqsec_tcdm_remap.sv
// tb_seqsec_tcdm_remap: directed self-checking bench for the seqsec TCDM remap stage
module tb_seqsec_tcdm_remap;
  import seqsec_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  size_t size = '0;
  logic bank_req, bank_gnt, bank_wen, bank_r_valid;
  logic [3:0] bank_sel, bank_be;
  logic [9:0] bank_row;
  logic [31:0] bank_wdata, bank_r_rdata;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  seqsec_tcdm_remap_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4)) core ();
  seqsec_tcdm_remap dut (
    .clk_i(clk), .rst_ni(rst_n), .seqsec_size_i(size), .core(core),
    .bank_req_o(bank_req), .bank_gnt_i(bank_gnt), .bank_sel_o(bank_sel), .bank_row_o(bank_row),
    .bank_wen_o(bank_wen), .bank_wdata_o(bank_wdata), .bank_be_o(bank_be),
    .bank_r_valid_i(bank_r_valid), .bank_r_rdata_i(bank_r_rdata)
  );
  // bank model: every grant answers exactly one cycle later, data tags the addressed location
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_r_valid <= 1'b0;
      bank_r_rdata <= '0;
    end else begin
      bank_r_valid <= bank_req && bank_gnt;
      bank_r_rdata <= 32'({bank_sel, bank_row});
    end
  end
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic xl(string tag, int w, int eb, int er);
    core.req = 1'b1;
    core.add = 32'(w) << 2;
    core.wen = 1'b1;
    bank_gnt = 1'b1;
    #1;
    check({tag, "_gnt"}, core.gnt, 1);
    tick();
    core.req = 1'b0;
    #1;
    check({tag, "_req"}, bank_req, 1);
    check({tag, "_sel"}, bank_sel, eb);
    check({tag, "_row"}, bank_row, er);
    check({tag, "_rv0"}, core.r_valid, 0);
    tick();
    check({tag, "_rv1"}, core.r_valid, 1);
    check({tag, "_rdata"}, core.r_rdata, 32'({4'(eb), 10'(er)}));
    tick();
  endtask
  task automatic set_size(size_t s);
    size = s;
    core.req = 1'b0;
    bank_gnt = 1'b1;
    tick();
    check("resize_drain_gnt", core.gnt, 0);
    tick();
    check("resize_run_gnt", core.gnt, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int acc, iss;
    core.req = 1'b0;
    core.add = '0;
    core.wen = 1'b1;
    core.wdata = '0;
    core.be = '0;
    bank_gnt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bank_req", bank_req, 0);
    rst_n = 1'b1;
    #1;
    check("rst_gnt", core.gnt, 1);
    check("rst_sel", bank_sel, 0);
    check("rst_row", bank_row, 0);
    check("rst_rvalid", core.r_valid, 0);
    xl("s0_w37", 37, 5, 2);
    set_size(4'd3);
    xl("s3_w37", 37, 9, 1);
    xl("s3_w70", 70, 6, 4);
    xl("s3_w63", 63, 15, 3);
    set_size(4'd12);
    xl("s12_w1500", 1500, 1, 476);
    set_size(4'd11);
    xl("s11_w1500", 1500, 1, 476);
    // backpressure: writes W=10..13 (bank 0, rows 10..13 under R=1024), bank grant low 3 cycles
    acc = 0;
    iss = 0;
    for (int c = 0; c < 20 && iss < 4; c++) begin
      core.req = acc < 4;
      core.add = 32'(10 + acc) << 2;
      core.wen = 1'b0;
      core.wdata = 32'hA000 + 32'(acc);
      core.be = 4'(acc + 1);
      bank_gnt = c >= 3;
      #1;
      if (c == 1 || c == 2) check("bp_gnt_low", core.gnt, 0);
      if (bank_req && bank_gnt) begin
        check("bp_row", bank_row, 10 + iss);
        check("bp_sel", bank_sel, 0);
        check("bp_wdata", bank_wdata, 32'hA000 + 32'(iss));
        check("bp_be", bank_be, iss + 1);
        check("bp_wen", bank_wen, 0);
        iss++;
      end
      if (core.req && core.gnt) acc++;
      tick();
    end
    check("bp_accepted", acc, 4);
    check("bp_issued", iss, 4);
    core.req = 1'b0;
    core.wen = 1'b1;
    bank_gnt = 1'b1;
    tick();
    set_size(4'd0);
    // resize 0->3 with one read outstanding and another request held in the stage
    core.req = 1'b1;
    core.add = 32'(37) << 2;
    #1;
    check("sc_a_gnt", core.gnt, 1);
    tick();
    core.add = 32'(20) << 2;
    size = 4'd3;
    #1;
    check("sc_b_gnt", core.gnt, 1);
    check("sc_b_req", bank_req, 1);
    tick();
    core.req = 1'b0;
    bank_gnt = 1'b0;
    #1;
    check("sc_c_gnt", core.gnt, 0);
    check("sc_c_rvalid", core.r_valid, 1);
    check("sc_c_sel_old_cfg", bank_sel, 4);
    check("sc_c_row_old_cfg", bank_row, 1);
    tick();
    check("sc_d_gnt", core.gnt, 0);
    check("sc_d_rvalid", core.r_valid, 0);
    bank_gnt = 1'b1;
    #1;
    check("sc_e_gnt", core.gnt, 0);
    tick();
    check("sc_f_gnt", core.gnt, 0);
    check("sc_f_rvalid", core.r_valid, 1);
    tick();
    check("sc_g_gnt", core.gnt, 0);
    tick();
    check("sc_h_gnt", core.gnt, 1);
    xl("sc_w20_new_cfg", 20, 5, 0);
    // reset with a request sitting in the stage
    core.req = 1'b1;
    core.add = 32'(37) << 2;
    bank_gnt = 1'b0;
    tick();
    core.req = 1'b0;
    check("mr_req_before", bank_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_req_in_reset", bank_req, 0);
    check("mr_sel_in_reset", bank_sel, 0);
    size = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mr_gnt_after", core.gnt, 1);
    check("mr_req_after", bank_req, 0);
    check("mr_rvalid_after", core.r_valid, 0);
    xl("mr_w37", 37, 5, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
